lcm_calc: RTL and testbench
===========================

LCM_CALC -- requirements
Module: lcm_calc

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; lcm output is 2*WIDTH wide.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  a, b, gcd_in presented valid.
REQ-005 Port: in_ready  output  1  block can accept an operand set.
REQ-006 Port: a  input  WIDTH  first operand.
REQ-007 Port: b  input  WIDTH  second operand.
REQ-008 Port: gcd_in  input  WIDTH  gcd(a,b) from the upstream GCD stage.
REQ-009 Port: out_valid  output  1  lcm and err valid.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: lcm  output  2*WIDTH  (a/gcd_in)*b.
REQ-012 Port: err  output  1  gcd_in is zero with nonzero operands, or does not divide a.

Function
REQ-013 The block SHALL implement FSM states IDLE, DIV, MUL, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; acceptance = in_valid & in_ready at a rising edge, capturing a, b, gcd_in into internal registers.
REQ-015 On acceptance with a==0 or b==0: lcm=0, err=0, next state DONE (result visible 1 cycle after the accepting edge).
REQ-016 On acceptance with a!=0, b!=0, gcd_in==0: lcm=0, err=1, next state DONE.
REQ-017 Otherwise next state DIV; DIV SHALL perform restoring division a/gcd_in, one quotient bit per cycle, MSB first, for exactly WIDTH cycles.
REQ-018 After the last DIV cycle, state SHALL become MUL; err SHALL be set to 1 if the final remainder is nonzero (computation continues with the floor quotient).
REQ-019 MUL SHALL perform shift-add multiplication quotient*b, one multiplier bit per cycle, exactly WIDTH cycles, into a 2*WIDTH accumulator; no overflow possible.
REQ-020 After the last MUL cycle, state SHALL become DONE with out_valid=1; total latency = 2*WIDTH cycles from the accepting edge to out_valid visible (64 for WIDTH=32).
REQ-021 In DONE, out_valid, lcm, err SHALL hold stable until out_ready=1 at a rising edge; then state IDLE, out_valid=0.
REQ-022 in_ready SHALL rise only in the cycle after the output transfer; no same-cycle output-transfer-and-input-accept.
REQ-023 in_valid and operand changes outside IDLE SHALL be ignored; captured operands SHALL not change mid-computation.
REQ-024 lcm and err SHALL keep their last result values in IDLE, DIV and MUL; only out_valid qualifies them.

Reset
REQ-025 rst=1 at a rising edge SHALL force state IDLE, in_ready=1, out_valid=0, lcm=0, err=0, and clear counter and datapath registers, from any state including mid-DIV/MUL.
REQ-026 rst SHALL take priority over in_valid and out_ready in the same cycle; an operation aborted by reset produces no output.

Verification
REQ-027 a=48, b=18, gcd_in=6, out_ready=1 -> out_valid 64 cycles after accept, lcm=144, err=0, in_ready=1 one cycle after transfer.
REQ-028 a=123456789, b=987654321, gcd_in=9 -> lcm=13548070123626141, err=0; a=0xFFFFFFFF, b=0xFFFFFFFE, gcd_in=1 -> lcm=0xFFFFFFFD00000002.
REQ-029 a=0, b=5, gcd_in=5 -> lcm=0, err=0 one cycle after accept; a=4, b=6, gcd_in=0 -> lcm=0, err=1 one cycle after accept.
REQ-030 a=10, b=4, gcd_in=3 -> err=1, lcm=12 after 64 cycles.
REQ-031 out_ready held 0 for 10 cycles in DONE while in_valid=1 with new operands -> out_valid, lcm, err stable, in_ready=0, new operands not captured; out_ready=1 releases.
REQ-032 rst pulsed at cycle 20 of a 48/18/6 operation -> next cycle in_ready=1, out_valid=0, lcm=0; a fresh 48/18/6 request then returns 144 after 64 cycles.

Source files
------------

// File: rtl/lcm_calc_if.sv
// Operand/result handshake bundle for lcm_calc: valid/ready on the operand side,
// valid/ready on the result side.
interface lcm_calc_if #(parameter int WIDTH = 32);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     gcd_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   lcm;
  logic                 err;

  modport master (
    output in_valid, a, b, gcd_in, out_ready,
    input  in_ready, out_valid, lcm, err
  );

  modport slave (
    input  in_valid, a, b, gcd_in, out_ready,
    output in_ready, out_valid, lcm, err
  );
endinterface

// File: rtl/lcm_calc.sv
// lcm = (a/gcd_in)*b via WIDTH-cycle restoring divide then WIDTH-cycle shift-add multiply (2*WIDTH latency, zero/err shortcuts visible next cycle).
// in_ready only in IDLE; result held in DONE until out_ready, and in_ready returns the cycle after that transfer.
module lcm_calc #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  lcm_calc_if.slave io
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     dvsr_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   lcm_q;
  logic                 err_pend_q;
  logic                 err_q;

  logic                 accept;
  logic                 zero_op;
  logic                 cnt_last;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_diff;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_nx;
  logic [2*WIDTH-1:0]   acc_nx;

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.lcm       = lcm_q;
  assign io.err       = err_q;

  assign accept   = io.in_valid && (state_q == IDLE);
  assign zero_op  = (io.a == '0) || (io.b == '0) || (io.gcd_in == '0);
  assign cnt_last = (cnt_q == CNT_LAST);

  // One restoring-division step and one shift-add step; the quotient register
  // doubles as the multiplier once division is finished.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, dvsr_q};
    q_bit    = ~rem_diff[WIDTH];
    rem_nx   = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    acc_nx   = acc_q + (quo_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)        state_d = zero_op ? DONE : DIV;
      DIV:  if (cnt_last)      state_d = MUL;
      MUL:  if (cnt_last)      state_d = DONE;
      DONE: if (io.out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      lcm_q      <= '0;
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            quo_q      <= io.a;
            rem_q      <= '0;
            dvsr_q     <= io.gcd_in;
            mcand_q    <= {{WIDTH{1'b0}}, io.b};
            acc_q      <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            if (zero_op) begin
              lcm_q <= '0;
              // both operands nonzero here means gcd_in was the zero
              err_q <= (io.a != '0) && (io.b != '0);
            end
          end
        end
        DIV: begin
          quo_q <= {quo_q[WIDTH-2:0], q_bit};
          rem_q <= rem_nx;
          cnt_q <= cnt_last ? '0 : cnt_q + CW'(1);
          if (cnt_last) err_pend_q <= (rem_nx != '0);
        end
        MUL: begin
          acc_q   <= acc_nx;
          quo_q   <= quo_q >> 1;
          mcand_q <= mcand_q << 1;
          cnt_q   <= cnt_last ? '0 : cnt_q + CW'(1);
          if (cnt_last) begin
            lcm_q <= acc_nx;
            err_q <= err_pend_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_calc.sv
// Directed bench for lcm_calc: hand-computed vectors, latency, backpressure, reset abort.
module tb_lcm_calc;
  localparam int W = 32;
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int nvec = 0;
  int nfail = 0;

  lcm_calc_if #(.WIDTH(W)) bus ();

  lcm_calc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  // Called at the negedge right after the accepting edge; lat = rising edges
  // after the accept edge before out_valid is seen (0 for the shortcuts).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.gcd_in = g;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nvec++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    nvec++; if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    nvec++; if (bus.lcm !== 64'd0) begin nfail++; $display("FAIL reset_lcm got %0d want 0", bus.lcm); end
    nvec++; if (bus.err !== 1'b0) begin nfail++; $display("FAIL reset_err got %b want 0", bus.err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    bus.out_ready = 1'b1;
    start_op(32'd48, 32'd18, 32'd6);
    nvec++; if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL basic_busy_in_ready got %b want 0", bus.in_ready); end
    wait_done(lat);
    nvec++; if (lat !== 64) begin nfail++; $display("FAIL basic_latency got %0d want 64", lat); end
    nvec++; if (bus.lcm !== 64'd144) begin nfail++; $display("FAIL basic_lcm got %0d want 144", bus.lcm); end
    nvec++; if (bus.err !== 1'b0) begin nfail++; $display("FAIL basic_err got %b want 0", bus.err); end
    @(negedge clk);
    nvec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      nfail++; $display("FAIL basic_after_xfer in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    nvec++; if (bus.lcm !== 64'd144) begin nfail++; $display("FAIL basic_hold_idle got %0d want 144", bus.lcm); end
  endtask

  task automatic test_large();
    int lat;
    bus.out_ready = 1'b1;
    start_op(32'd123456789, 32'd987654321, 32'd9);
    wait_done(lat);
    nvec++; if (lat !== 64) begin nfail++; $display("FAIL large1_latency got %0d want 64", lat); end
    nvec++; if (bus.lcm !== 64'd13548070123626141) begin nfail++; $display("FAIL large1_lcm got %0d want 13548070123626141", bus.lcm); end
    nvec++; if (bus.err !== 1'b0) begin nfail++; $display("FAIL large1_err got %b want 0", bus.err); end
    @(negedge clk);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
    wait_done(lat);
    nvec++; if (bus.lcm !== 64'hFFFF_FFFD_0000_0002) begin nfail++; $display("FAIL large2_lcm got %h want fffffffd00000002", bus.lcm); end
    nvec++; if (bus.err !== 1'b0) begin nfail++; $display("FAIL large2_err got %b want 0", bus.err); end
    @(negedge clk);
  endtask

  task automatic test_shortcuts();
    int lat;
    bus.out_ready = 1'b1;
    start_op(32'd0, 32'd5, 32'd5);
    wait_done(lat);
    nvec++; if (lat !== 0) begin nfail++; $display("FAIL zero_op_latency got %0d want 0", lat); end
    nvec++; if (bus.lcm !== 64'd0 || bus.err !== 1'b0) begin
      nfail++; $display("FAIL zero_op_result lcm=%0d err=%b want 0/0", bus.lcm, bus.err);
    end
    @(negedge clk);
    start_op(32'd4, 32'd6, 32'd0);
    wait_done(lat);
    nvec++; if (lat !== 0) begin nfail++; $display("FAIL gcd0_latency got %0d want 0", lat); end
    nvec++; if (bus.lcm !== 64'd0 || bus.err !== 1'b1) begin
      nfail++; $display("FAIL gcd0_result lcm=%0d err=%b want 0/1", bus.lcm, bus.err);
    end
    @(negedge clk);
  endtask

  task automatic test_inexact();
    int lat;
    bus.out_ready = 1'b1;
    start_op(32'd10, 32'd4, 32'd3);
    wait_done(lat);
    nvec++; if (lat !== 64) begin nfail++; $display("FAIL inexact_latency got %0d want 64", lat); end
    nvec++; if (bus.lcm !== 64'd12 || bus.err !== 1'b1) begin
      nfail++; $display("FAIL inexact_result lcm=%0d err=%b want 12/1", bus.lcm, bus.err);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    start_op(32'd48, 32'd18, 32'd6);
    wait_done(lat);
    nvec++; if (lat !== 64) begin nfail++; $display("FAIL bp_latency got %0d want 64", lat); end
    bus.in_valid = 1'b1;
    bus.a = 32'd7;
    bus.b = 32'd9;
    bus.gcd_in = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nvec++;
      if (bus.out_valid !== 1'b1 || bus.lcm !== 64'd144 || bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin
        nfail++;
        $display("FAIL bp_hold cycle %0d out_valid=%b lcm=%0d err=%b in_ready=%b want 1/144/0/0",
                 i, bus.out_valid, bus.lcm, bus.err, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    nvec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.lcm !== 64'd144) begin
      nfail++; $display("FAIL bp_release out_valid=%b in_ready=%b lcm=%0d want 0/1/144", bus.out_valid, bus.in_ready, bus.lcm);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic seen;
    bus.out_ready = 1'b1;
    start_op(32'd48, 32'd18, 32'd6);
    repeat (19) @(negedge clk);
    // reset must beat a simultaneous request
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 32'd3;
    bus.b = 32'd5;
    bus.gcd_in = 32'd1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    nvec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.lcm !== 64'd0) begin
      nfail++; $display("FAIL abort_state in_ready=%b out_valid=%b lcm=%0d want 1/0/0", bus.in_ready, bus.out_valid, bus.lcm);
    end
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    nvec++; if (seen !== 1'b0) begin nfail++; $display("FAIL abort_no_output got out_valid=1 want none"); end
    start_op(32'd48, 32'd18, 32'd6);
    wait_done(lat);
    nvec++; if (lat !== 64 || bus.lcm !== 64'd144) begin
      nfail++; $display("FAIL abort_fresh lat=%0d lcm=%0d want 64/144", lat, bus.lcm);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 32'd3;
    bus.b = 32'd5;
    bus.gcd_in = 32'd1;
    @(negedge clk);
    // changes while busy must not leak into the running operation
    bus.a = 32'd100;
    bus.b = 32'd100;
    bus.gcd_in = 32'd100;
    wait_done(lat);
    nvec++; if (lat !== 64 || bus.lcm !== 64'd15) begin
      nfail++; $display("FAIL b2b_first lat=%0d lcm=%0d want 64/15", lat, bus.lcm);
    end
    @(negedge clk);
    nvec++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL b2b_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done(lat);
    nvec++; if (lat !== 64 || bus.lcm !== 64'd100 || bus.err !== 1'b0) begin
      nfail++; $display("FAIL b2b_second lat=%0d lcm=%0d err=%b want 64/100/0", lat, bus.lcm, bus.err);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.gcd_in = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_large();
    test_shortcuts();
    test_inexact();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
